// File: rtl/execute_stage_cc_pkg.sv
// execute_stage_cc_pkg: shared ALU encodings, forward selects, multiply FSM states and ALU helper.
package execute_stage_cc_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_MUL
  } alu_op_e;
  typedef enum logic [1:0] {FWD_REG, FWD_WB, FWD_MEM} fwd_sel_e;
  typedef enum logic [1:0] {MS_IDLE, MS_BUSY, MS_DONE} mul_state_e;
  localparam int XLEN = 32;
  function automatic logic [XLEN-1:0] alu_eval(input logic [3:0] op, input logic [XLEN-1:0] a, b);
    case (op)
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      default:  return a + b;
    endcase
  endfunction
endpackage

// File: rtl/execute_stage_cc_if.sv
// execute_stage_cc_if: ID/EX inputs and EX/MEM outputs of the execute stage.
interface execute_stage_cc_if;
  logic        RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, BranchE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, ResultW;
  logic [4:0]  RDE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        RegWriteM, ResultSrcM, MemWriteM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        PCSrcE, StallE;
  logic [31:0] PCTargetE;
  modport master (
    output RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, BranchE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, ResultW, RDE, ForwardAE, ForwardBE,
    input  RegWriteM, ResultSrcM, MemWriteM, RDM, ALUResultM, WriteDataM,
           PCSrcE, StallE, PCTargetE
  );
  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE, ALUSrcE, BranchE, ALUControlE,
           RD1E, RD2E, ImmExtE, PCE, ResultW, RDE, ForwardAE, ForwardBE,
    output RegWriteM, ResultSrcM, MemWriteM, RDM, ALUResultM, WriteDataM,
           PCSrcE, StallE, PCTargetE
  );
endinterface

// File: rtl/execute_stage_cc_mul.sv
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per cycle, low 32 product bits.
module seq_multiplier
  import execute_stage_cc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);
  mul_state_e      r_state, w_next;
  logic [XLEN-1:0] r_a, r_b, r_acc;
  logic [4:0]      r_count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MS_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == MS_IDLE && i_start) begin
        r_a     <= i_a;
        r_b     <= i_b;
        r_acc   <= '0;
        r_count <= '0;
      end else if (r_state == MS_BUSY) begin
        r_acc   <= r_acc + (r_b[0] ? r_a : '0);
        r_a     <= r_a << 1;
        r_b     <= r_b >> 1;
        r_count <= r_count + 5'd1;
      end
    end
  end
  // Busy is gated by reset so the stall drops the moment reset asserts.
  always_comb begin
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      MS_IDLE: begin
        o_busy = i_start & rst;
        w_next = i_start ? MS_BUSY : MS_IDLE;
      end
      MS_BUSY: begin
        o_busy = 1'b1;
        w_next = (r_count == 5'd31) ? MS_DONE : MS_BUSY;
      end
      MS_DONE: begin
        o_done = 1'b1;
        w_next = MS_IDLE;
      end
      default: w_next = MS_IDLE;
    endcase
  end
  assign o_product = r_acc;
endmodule

// File: rtl/execute_stage_cc.sv
// execute_stage_cc: RISC-V execute stage with forwarding, branch resolve, iterative MUL and EX/MEM register.
module execute_stage_cc
  import execute_stage_cc_pkg::*;
(
  input logic clk,
  input logic rst,
  execute_stage_cc_if.slave bus
);
  logic [XLEN-1:0] w_src_a, w_fwd_b, w_src_b, w_alu, w_product;
  logic            w_stall, w_done, w_start;
  assign w_src_a = (bus.ForwardAE == FWD_MEM) ? bus.ALUResultM :
                   (bus.ForwardAE == FWD_WB)  ? bus.ResultW : bus.RD1E;
  assign w_fwd_b = (bus.ForwardBE == FWD_MEM) ? bus.ALUResultM :
                   (bus.ForwardBE == FWD_WB)  ? bus.ResultW : bus.RD2E;
  assign w_src_b = bus.ALUSrcE ? bus.ImmExtE : w_fwd_b;
  assign w_alu   = alu_eval(bus.ALUControlE, w_src_a, w_src_b);
  assign w_start = bus.ALUControlE == ALU_MUL;
  seq_multiplier u_mul (
    .clk(clk), .rst(rst), .i_start(w_start), .i_a(w_src_a), .i_b(w_src_b),
    .o_busy(w_stall), .o_done(w_done), .o_product(w_product)
  );
  assign bus.StallE    = w_stall;
  assign bus.PCSrcE    = bus.BranchE & (w_src_a == w_fwd_b) & ~w_stall;
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;
  // A stalled stage pushes a bubble; the DONE cycle carries the product with the MUL's controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || w_stall) begin
      bus.RegWriteM  <= 1'b0;
      bus.ResultSrcM <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.RDM        <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
    end else begin
      bus.RegWriteM  <= bus.RegWriteE;
      bus.ResultSrcM <= bus.ResultSrcE;
      bus.MemWriteM  <= bus.MemWriteE;
      bus.RDM        <= bus.RDE;
      bus.ALUResultM <= w_done ? w_product : w_alu;
      bus.WriteDataM <= w_fwd_b;
    end
  end
endmodule

// File: tb/tb_execute_stage_cc.sv
// tb_execute_stage_cc: directed and randomized checks of execute_stage_cc against an occupancy-level reference model.
module tb_execute_stage_cc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  execute_stage_cc_if bus();
  execute_stage_cc dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0, n_err = 0;
  logic        m_rw, m_rs, m_mw, last_stall;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_prod;
  int          occ, stall_cnt;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    r = (a < b) ? 32'd1 : 32'd0;
      4'd7:    r = a << b[4:0];
      4'd8:    r = a >> b[4:0];
      4'd9:    r = $signed(a) >>> b[4:0];
      4'd10:   r = a * b;
      default: r = a + b;
    endcase
    return r;
  endfunction
  function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] rd);
    return (s == 2'd2) ? m_alu : (s == 2'd1) ? bus.ResultW : rd;
  endfunction
  task automatic model_reset();
    {m_rw, m_rs, m_mw} = 3'b000;
    m_rd = '0; m_alu = '0; m_wd = '0; occ = 0;
  endtask
  task automatic check_m(input string tag);
    check({tag, "_regwrite"}, {31'd0, bus.RegWriteM}, {31'd0, m_rw});
    check({tag, "_resultsrc"}, {31'd0, bus.ResultSrcM}, {31'd0, m_rs});
    check({tag, "_memwrite"}, {31'd0, bus.MemWriteM}, {31'd0, m_mw});
    check({tag, "_rd"}, {27'd0, bus.RDM}, {27'd0, m_rd});
    check({tag, "_alu"}, bus.ALUResultM, m_alu);
    check({tag, "_wdata"}, bus.WriteDataM, m_wd);
  endtask
  // A MUL occupies the stage for 34 cycles: 33 stalled, result loaded on the 34th edge.
  task automatic cyc(input string tag);
    logic [31:0] a, fb, b;
    logic stall;
    #1;
    a  = pick(bus.ForwardAE, bus.RD1E);
    fb = pick(bus.ForwardBE, bus.RD2E);
    b  = bus.ALUSrcE ? bus.ImmExtE : fb;
    if (occ == 0 && bus.ALUControlE == 4'd10) begin
      occ = 1;
      m_prod = a * b;
    end
    stall = (occ >= 1 && occ <= 33);
    last_stall = bus.StallE;
    check({tag, "_stall"}, {31'd0, bus.StallE}, {31'd0, stall});
    check({tag, "_pcsrc"}, {31'd0, bus.PCSrcE}, {31'd0, bus.BranchE && (a == fb) && !stall});
    check({tag, "_pctarget"}, bus.PCTargetE, bus.PCE + bus.ImmExtE);
    @(posedge clk);
    if (stall) model_reset_data();
    else begin
      m_rw = bus.RegWriteE; m_rs = bus.ResultSrcE; m_mw = bus.MemWriteE; m_rd = bus.RDE;
      m_alu = (occ == 34) ? m_prod : ref_alu(bus.ALUControlE, a, b);
      m_wd = fb;
    end
    occ = (occ == 0 || occ == 34) ? 0 : occ + 1;
    #1;
    check_m(tag);
  endtask
  task automatic model_reset_data();
    {m_rw, m_rs, m_mw} = 3'b000;
    m_rd = '0; m_alu = '0; m_wd = '0;
  endtask
  task automatic clear_inputs();
    {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.ALUSrcE, bus.BranchE} = 5'b0;
    bus.ALUControlE = '0; bus.RD1E = '0; bus.RD2E = '0; bus.ImmExtE = '0; bus.PCE = '0;
    bus.ResultW = '0; bus.RDE = '0; bus.ForwardAE = '0; bus.ForwardBE = '0;
  endtask
  task automatic set_mul(input logic [31:0] x, input logic [31:0] y);
    clear_inputs();
    bus.ALUControlE = 4'd10; bus.RD1E = x; bus.RD2E = y; bus.RegWriteE = 1'b1; bus.RDE = 5'd9;
  endtask
  initial begin
    clear_inputs();
    model_reset();
    #12;
    check_m("reset");
    check("reset_stall", {31'd0, bus.StallE}, 32'd0);
    rst = 1'b1;
    bus.RD1E = 32'd5; bus.RD2E = 32'd7; bus.RegWriteE = 1'b1; bus.RDE = 5'd3;
    cyc("add");
    check("add_result", bus.ALUResultM, 32'd12);
    bus.RD1E = 32'd60; bus.RD2E = 32'd40;
    cyc("add100");
    bus.ALUControlE = 4'd1; bus.ForwardAE = 2'd2; bus.ForwardBE = 2'd1; bus.ResultW = 32'd3;
    cyc("fwd_sub");
    check("fwd_sub_result", bus.ALUResultM, 32'd97);
    clear_inputs();
    bus.BranchE = 1'b1; bus.RD1E = 32'd9; bus.RD2E = 32'd9; bus.PCE = 32'h100; bus.ImmExtE = 32'h20;
    #1;
    check("beq_pcsrc", {31'd0, bus.PCSrcE}, 32'd1);
    check("beq_target", bus.PCTargetE, 32'h120);
    cyc("beq");
    set_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.ALUSrcE = 1'b1; bus.ImmExtE = 32'd3; bus.BranchE = 1'b1; bus.PCE = 32'h100;
    #1;
    check("beq_in_stall_pcsrc", {31'd0, bus.PCSrcE}, 32'd0);
    stall_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      cyc("mul_ff3");
      stall_cnt += int'(last_stall);
    end
    check("mul_stall_cycles", stall_cnt, 33);
    check("mul_ff3_result", bus.ALUResultM, 32'hFFFF_FFFD);
    check("mul_ff3_regwrite", {31'd0, bus.RegWriteM}, 32'd1);
    set_mul(32'd6, 32'd7);
    for (int i = 0; i < 34; i++) begin
      if (i >= 1 && i <= 32) begin
        bus.ResultW = $urandom;
        bus.ForwardAE = 2'($urandom_range(0, 3));
        bus.ForwardBE = 2'($urandom_range(0, 3));
      end else begin
        bus.ForwardAE = 2'd0; bus.ForwardBE = 2'd0;
      end
      cyc("mul_fwd_toggle");
    end
    check("mul_fwd_toggle_result", bus.ALUResultM, 32'd42);
    set_mul(32'd6, 32'd7);
    for (int i = 0; i < 16; i++) cyc("mul_pre_reset");
    rst = 1'b0;
    model_reset();
    #1;
    check_m("async_reset");
    check("async_reset_stall", {31'd0, bus.StallE}, 32'd0);
    @(posedge clk);
    #1;
    check_m("held_reset");
    rst = 1'b1;
    for (int i = 0; i < 34; i++) cyc("mul_after_reset");
    check("mul_after_reset_result", bus.ALUResultM, 32'd42);
    for (int n = 0; n < 120; n++) begin
      bus.RegWriteE = 1'($urandom); bus.ResultSrcE = 1'($urandom); bus.MemWriteE = 1'($urandom);
      bus.ALUSrcE = 1'($urandom); bus.BranchE = 1'($urandom);
      bus.ALUControlE = ($urandom_range(0, 4) == 0) ? 4'd10 : 4'($urandom);
      bus.RD1E = $urandom; bus.RD2E = ($urandom_range(0, 1) == 1) ? bus.RD1E : $urandom;
      bus.ImmExtE = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      bus.PCE = $urandom; bus.ResultW = $urandom; bus.RDE = 5'($urandom);
      bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
      if (bus.ALUControlE == 4'd10) begin
        for (int i = 0; i < 34; i++) begin
          if (i >= 1) begin
            bus.ResultW = $urandom;
            bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
          end
          cyc("rand_mul");
        end
      end else cyc("rand_op");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/execute_stage_cc.md
EXECUTE_STAGE_CC -- requirements
Module: execute_stage_cc

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning (clock and reset first).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteE, ResultSrcE, MemWriteE, ALUSrcE  in  1 each  decoded controls from the ID/EX register.
- ALUControlE  in  4  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL; 11-15 behave as ADD.
- BranchE  in  1  conditional branch (BEQ).
- RD1E, RD2E, ImmExtE, PCE  in  32 each  operands, immediate, PC.
- RDE  in  5  destination register.
- ForwardAE, ForwardBE  in  2 each  source select: 0 register, 1 ResultW, 2 ALUResultM.
- ResultW  in  32  writeback result for forwarding.
- RegWriteM, ResultSrcM, MemWriteM  out  1 each  registered controls to memory stage.
- RDM  out  5  registered destination.
- ALUResultM, WriteDataM  out  32 each  registered ALU result and store data.
- PCSrcE  out  1  combinational taken-branch flag.
- PCTargetE  out  32  combinational PCE + ImmExtE.
- StallE  out  1  combinational: execute stage occupied by a multiply; upstream freezes.

Function
REQ-002 SrcA SHALL be the ForwardAE-selected value; forwarded B SHALL be the ForwardBE-selected value; SrcB SHALL be ImmExtE when ALUSrcE=1, else forwarded B; select value 3 SHALL behave as 0.
REQ-003 WriteDataM SHALL capture forwarded B, never ImmExtE.
REQ-004 Single-cycle ops SHALL be 32-bit modulo; shifts SHALL use SrcB[4:0]; SLT signed, SLTU unsigned, result 0 or 1.
REQ-005 PCSrcE SHALL equal BranchE AND (SrcA == forwarded B); PCTargetE SHALL be 32-bit modulo.
REQ-006 MUL SHALL produce the low 32 bits of SrcA*SrcB using an iterative shift-add datapath, one multiplier bit per cycle.
REQ-007 The multiply FSM SHALL have states IDLE, BUSY, DONE.
REQ-008 IDLE with ALUControlE=10: latch SrcA and SrcB, clear accumulator, count=0, go to BUSY, StallE=1.
REQ-009 BUSY: one add/shift step per cycle, StallE=1; leave for DONE after the 32nd step (count=31).
REQ-010 DONE: StallE=0, ALUResultM captures the product with the MUL's controls, return to IDLE; total MUL occupancy SHALL be 34 cycles.
REQ-011 While StallE=1, the EX/MEM register SHALL load a bubble: RegWriteM=0, MemWriteM=0, ResultSrcM=0, RDM=0, data 0.
REQ-012 Operands latched in IDLE SHALL be used exclusively; ResultW or forward-select changes during BUSY SHALL NOT affect the product.
REQ-013 PCSrcE SHALL be forced to 0 while StallE=1.
REQ-014 Non-MUL ops in IDLE SHALL register into EX/MEM every cycle with one-cycle latency and StallE=0.
REQ-015 Back-to-back MULs SHALL each take 34 cycles with no overlap.

Reset
REQ-016 rst=0 SHALL immediately force all EX/MEM outputs to 0, FSM to IDLE, counter, operand and accumulator registers to 0, and StallE to 0, including mid-multiply.
REQ-017 After rst releases, a MUL still presented on ALUControlE SHALL restart from IDLE with a full 34-cycle occupancy.

Structure
REQ-018 ALUControl encodings, forward-select codes and FSM state encodings SHALL live in a shared package used by decode, hazard and execute logic.
REQ-019 The iterative multiplier SHALL be a sub-module named seq_multiplier (start/busy/done handshake, 32-bit operands, 32-bit product); the ALU and EX/MEM register SHALL stay in this module.

Verification
REQ-020 ADD, forwarding off: RD1E=5, RD2E=7 -> ALUResultM=12 one edge later, StallE=0.
REQ-021 Forwarding: ForwardAE=2 with ALUResultM=100, ForwardBE=1 with ResultW=3, SUB -> ALUResultM=97.
REQ-022 MUL 0xFFFFFFFF*3 -> StallE high for 33 cycles, bubbles meanwhile, ALUResultM=0xFFFFFFFD with RegWriteM=1 on the 34th edge.
REQ-023 BEQ with equal operands, PCE=0x100, ImmExtE=0x20 -> PCSrcE=1, PCTargetE=0x120; same case during a MUL stall -> PCSrcE=0.
REQ-024 rst=0 at BUSY step 15 -> outputs 0, StallE=0 immediately; after release, the held MUL 6*7 returns 42 after 34 cycles.
REQ-025 Toggle ResultW during BUSY for MUL 6*7 -> product remains 42.
